instruction_fetch_unit: RTL and testbench

Sequencer that drives the synchronous-read instruction memory (1-cycle read latency, word-addressed). It owns the fetch PC and tracks the in-flight read. It buffers returned words in a 2-entry queue so downstream stalls never lose data, and offers instructions to decode over a valid/ready handshake. It handles start, redirect (branch/jump) with flush, and halt-on-zero-word program termination.

---
 rtl/instruction_fetch_unit_pkg.sv | 14 +
 rtl/instruction_fetch_unit_fetch_queue.sv | 67 ++++++
 rtl/instruction_fetch_unit.sv | 110 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and queue sizing.
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } ifu_state_t;

   localparam int QUEUE_DEPTH = 2;
   localparam int HALT_WORD   = 0;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Two-entry FIFO of {word, pc}; entry0 is always the head so the outputs come straight from a register.
module instruction_fetch_unit_fetch_queue
   import instruction_fetch_unit_pkg::*;
#(
   parameter int WIDTH = 42
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head,
   output logic [1:0]       o_count,
   output logic             o_valid
);

   logic [WIDTH-1:0] r_entry0;
   logic [WIDTH-1:0] r_entry1;
   logic [1:0]       r_count;
   logic             w_pop;
   logic             w_full;

   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_full = (r_count == 2'(QUEUE_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_entry0 <= '0;
         r_entry1 <= '0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_count <= 2'd0;
      end else begin
         case ({i_push, w_pop})
            2'b10: begin
               if (!w_full) begin
                  if (r_count == 2'd0) r_entry0 <= i_data;
                  else                 r_entry1 <= i_data;
                  r_count <= r_count + 2'd1;
               end
            end
            2'b01: begin
               // Leave entry0 untouched when emptying so the outputs hold their last value.
               if (r_count == 2'd2) r_entry0 <= r_entry1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_entry0 <= i_data;
               end else begin
                  r_entry0 <= r_entry1;
                  r_entry1 <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(i_push && w_full && !w_pop));

   assign o_head  = r_entry0;
   assign o_count = r_count;
   assign o_valid = (r_count != 2'd0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer for a 1-cycle synchronous instruction memory: owns the PC, tracks the
// single in-flight read, buffers returns in a 2-entry queue and handles start/redirect/halt.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int RESET_PC     = 0,
   parameter bit HALT_ON_ZERO = 1'b1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_data,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_out,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  busy,
   output logic                  halted,
   output logic [1:0]            dbg_state
);

   localparam int                    QW      = DATA_WIDTH + ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

   ifu_state_t            r_state;
   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_inflight_pc;
   logic                  r_inflight;

   logic                  w_pop;
   logic                  w_push;
   logic                  w_halt_word;
   logic                  w_issue;
   logic [1:0]            w_count;
   logic [2:0]            w_credit;
   logic [QW-1:0]         w_head;

   // Decode handshake: instr_out/instr_pc transfer on a clock edge where instr_valid and
   // instr_ready are both high; while instr_valid is high and instr_ready low the head is
   // held stable and instr_valid cannot drop except through redirect or reset.
   assign w_pop = instr_valid && instr_ready;

   assign w_halt_word = HALT_ON_ZERO && r_inflight && (imem_data == DATA_WIDTH'(HALT_WORD));
   assign w_push      = r_inflight && !w_halt_word && !redirect_valid;

   // Credit: queued + in-flight words after this cycle's pop must leave room for one more.
   assign w_credit = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue  = (r_state == ST_FETCH) && !w_halt_word && (w_credit < 3'(QUEUE_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_fetch_pc    <= PC_INIT;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else if (redirect_valid) begin
         r_state    <= ST_FETCH;
         r_fetch_pc <= redirect_addr;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + ADDR_WIDTH'(1);
         end
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state    <= ST_FETCH;
                  r_fetch_pc <= PC_INIT;
               end
            end
            ST_FETCH: begin
               if (w_halt_word) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_count == 2'd0) r_state <= ST_HALTED;
            end
            default: ;
         endcase
      end
   end

   instruction_fetch_unit_fetch_queue #(
      .WIDTH (QW)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  ({imem_data, r_inflight_pc}),
      .o_head  (w_head),
      .o_count (w_count),
      .o_valid (instr_valid)
   );

   assign imem_addr = r_fetch_pc;
   assign instr_out = w_head[QW-1:ADDR_WIDTH];
   assign instr_pc  = w_head[ADDR_WIDTH-1:0];
   assign busy      = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
   assign halted    = (r_state == ST_HALTED);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural instruction memory and
// an expected-instruction queue checked on every accepted handshake.
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic        redirect_valid;
   logic [9:0]  redirect_addr;
   logic [9:0]  imem_addr;
   logic [31:0] imem_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [9:0]  instr_pc;
   logic        busy;
   logic        halted;
   logic [1:0]  dbg_state;

   logic [31:0] mem [0:1023];
   logic [41:0] exp_q[$];
   int          total;
   int          bad;

   instruction_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .busy           (busy),
      .halted         (halted),
      .dbg_state      (dbg_state)
   );

   // Clock and memory
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) imem_data <= mem[imem_addr];

   initial begin
      #100000;
      $display("FAIL watchdog: observed=still running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_pc(input logic [9:0] pc);
      exp_q.push_back({pc, mem[pc]});
   endtask

   // One clock: score any handshake completing this cycle, then advance to edge+1.
   task automatic step();
      logic [41:0] e;
      if (instr_valid && instr_ready) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL spurious_instr: observed pc=%0d word=%h expected=none", instr_pc, instr_out);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("instr", {22'd0, instr_pc, instr_out}, {22'd0, e});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input int max_cycles);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         step();
         n++;
      end
      check("drain_done", exp_q.size(), 0);
   endtask

   task automatic wait_halt(input int max_cycles);
      int n = 0;
      while (!halted && n < max_cycles) begin
         step();
         n++;
      end
      check("halted", halted, 1'b1);
      check("halted_busy", busy, 1'b0);
      check("halted_state", dbg_state, ST_HALTED);
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rst            = 1'b1;
      start          = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      instr_ready    = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom | 32'h1;
      mem[0] = 32'h16E00C00;
      mem[1] = 32'h16E10C01;
      mem[7] = 32'h1AE60FFF;
      mem[8] = 32'h0;

      // Reset state
      step();
      step();
      check("rst_valid", instr_valid, 1'b0);
      check("rst_addr", imem_addr, 10'd0);
      check("rst_out", instr_out, 32'd0);
      check("rst_pc", instr_pc, 10'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_state", dbg_state, ST_IDLE);
      rst = 1'b0;

      // Program load: start in cycle 0, stream pcs 0..7, halt on zero at pc 8
      start       = 1'b1;
      instr_ready = 1'b1;
      for (int p = 0; p < 8; p++) expect_pc(10'(p));
      step();
      start = 1'b0;
      check("c1_valid", instr_valid, 1'b0);
      check("c1_busy", busy, 1'b1);
      check("c1_addr", imem_addr, 10'd0);
      step();
      check("c2_valid", instr_valid, 1'b0);
      check("c2_addr", imem_addr, 10'd1);
      step();
      for (int k = 0; k < 8; k++) begin
         check("stream_valid", instr_valid, 1'b1);
         step();
      end
      check("no_zero_word", instr_valid, 1'b0);
      check("drained", exp_q.size(), 0);
      step();
      check("halt_cycle12", halted, 1'b1);
      check("halt_busy", busy, 1'b0);

      // Restart from HALTED: start ignored, redirect to 4 resumes
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_ignored_state", dbg_state, ST_HALTED);
      check("start_ignored_halted", halted, 1'b1);
      redirect_valid = 1'b1;
      redirect_addr  = 10'd4;
      instr_ready    = 1'b0;
      step();
      redirect_valid = 1'b0;
      check("rh_t1_valid", instr_valid, 1'b0);
      check("rh_t1_addr", imem_addr, 10'd4);
      check("rh_t1_busy", busy, 1'b1);
      step();
      check("rh_t2_valid", instr_valid, 1'b0);
      step();
      check("rh_t3_valid", instr_valid, 1'b1);
      check("rh_t3_pc", instr_pc, 10'd4);
      check("rh_t3_word", instr_out, mem[4]);
      for (int p = 4; p < 8; p++) expect_pc(10'(p));
      instr_ready = 1'b1;
      wait_empty(20);
      wait_halt(10);

      // Backpressure: ready low for cycles 3..10 after a fresh start
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("bp_rst_state", dbg_state, ST_IDLE);
      start       = 1'b1;
      instr_ready = 1'b0;
      for (int p = 0; p < 8; p++) expect_pc(10'(p));
      step();
      start = 1'b0;
      step();
      step();
      for (int c = 3; c <= 10; c++) begin
         check("bp_valid", instr_valid, 1'b1);
         check("bp_word", instr_out, 32'h16E00C00);
         check("bp_pc", instr_pc, 10'd0);
         check("bp_addr", imem_addr, 10'd2);
         step();
      end
      instr_ready = 1'b1;
      wait_empty(30);
      wait_halt(10);

      // Redirect while pc 3 at head: pcs 4,5 must never appear
      rst = 1'b1;
      step();
      rst   = 1'b0;
      start = 1'b1;
      for (int p = 0; p < 4; p++) expect_pc(10'(p));
      step();
      start = 1'b0;
      begin
         int n = 0;
         while (exp_q.size() > 1 && n < 20) begin
            step();
            n++;
         end
      end
      check("rd_head_valid", instr_valid, 1'b1);
      check("rd_head_pc", instr_pc, 10'd3);
      redirect_valid = 1'b1;
      redirect_addr  = 10'd6;
      step();
      redirect_valid = 1'b0;
      check("rd_flush_valid", instr_valid, 1'b0);
      check("rd_addr", imem_addr, 10'd6);
      expect_pc(10'd6);
      expect_pc(10'd7);
      wait_empty(20);
      wait_halt(10);

      // Redirect over halt: redirect to 0 while the zero word at pc 8 is in flight
      redirect_valid = 1'b1;
      redirect_addr  = 10'd0;
      for (int p = 0; p < 8; p++) expect_pc(10'(p));
      step();
      redirect_valid = 1'b0;
      for (int k = 0; k < 9; k++) step();
      check("oh_head_pc", instr_pc, 10'd7);
      check("oh_head_valid", instr_valid, 1'b1);
      redirect_valid = 1'b1;
      redirect_addr  = 10'd0;
      step();
      redirect_valid = 1'b0;
      check("oh_not_halted", halted, 1'b0);
      check("oh_state", dbg_state, ST_FETCH);
      check("oh_valid", instr_valid, 1'b0);
      for (int p = 0; p < 3; p++) expect_pc(10'(p));
      wait_empty(20);
      instr_ready = 1'b0;
      check("oh_busy", busy, 1'b1);

      // Wrap 1022 -> 1023 -> 0, then reset mid-stream
      redirect_valid = 1'b1;
      redirect_addr  = 10'd1022;
      step();
      redirect_valid = 1'b0;
      expect_pc(10'd1022);
      expect_pc(10'd1023);
      expect_pc(10'd0);
      instr_ready = 1'b1;
      wait_empty(20);
      instr_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", instr_valid, 1'b0);
      check("mid_rst_state", dbg_state, ST_IDLE);
      check("mid_rst_addr", imem_addr, 10'd0);
      check("mid_rst_busy", busy, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("post_rst_valid", instr_valid, 1'b0);
         check("post_rst_state", dbg_state, ST_IDLE);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
